// File: rtl/dual_issue_scheduler_if.sv
// rtl/dual_issue_scheduler_if.sv - decode pair, flush and issue bundle for the dual-issue scheduler
interface dual_issue_scheduler_if #(
    parameter int REG_W = 7,
    parameter int LAT_W = 4,
    parameter int CNT_W = 32
);
    logic             pair_valid;
    logic             pair_ready;
    logic             i1_type, i1_wr, i1_nop;
    logic [REG_W-1:0] i1_dst, i1_ra, i1_rb, i1_rc;
    logic             i1_use_ra, i1_use_rb, i1_use_rc;
    logic [LAT_W-1:0] i1_lat;
    logic             i2_type, i2_wr, i2_nop;
    logic [REG_W-1:0] i2_dst, i2_ra, i2_rb, i2_rc;
    logic             i2_use_ra, i2_use_rb, i2_use_rc;
    logic [LAT_W-1:0] i2_lat;
    logic             flush;
    logic             even_issue, even_slot;
    logic             odd_issue, odd_slot;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output pair_valid, flush,
        output i1_type, i1_wr, i1_nop, i1_dst, i1_ra, i1_rb, i1_rc,
        output i1_use_ra, i1_use_rb, i1_use_rc, i1_lat,
        output i2_type, i2_wr, i2_nop, i2_dst, i2_ra, i2_rb, i2_rc,
        output i2_use_ra, i2_use_rb, i2_use_rc, i2_lat,
        input  pair_ready, even_issue, even_slot, odd_issue, odd_slot, stall, stall_count
    );

    modport slave (
        input  pair_valid, flush,
        input  i1_type, i1_wr, i1_nop, i1_dst, i1_ra, i1_rb, i1_rc,
        input  i1_use_ra, i1_use_rb, i1_use_rc, i1_lat,
        input  i2_type, i2_wr, i2_nop, i2_dst, i2_ra, i2_rb, i2_rc,
        input  i2_use_ra, i2_use_rb, i2_use_rc, i2_lat,
        output pair_ready, even_issue, even_slot, odd_issue, odd_slot, stall, stall_count
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - in-order dual-issue controller with per-register latency scoreboard
module dual_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int REG_W    = 7,
    parameter int LAT_W    = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dual_issue_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PAIR, SECOND} state_t;

    typedef struct packed {
        logic             typ;
        logic             wr;
        logic             nop;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic             use_ra;
        logic             use_rb;
        logic             use_rc;
        logic [LAT_W-1:0] lat;
    } instr_t;

    state_t           state, state_n;
    instr_t           in1, in2, h1, h2;
    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] stall_cnt;
    logic             rdy1, rdy2, w1, w2, rd_dep, pair_ok;
    logic             iss1, iss2, ready_i, stall_i, accept;

    assign in1 = '{typ: bus.i1_type, wr: bus.i1_wr, nop: bus.i1_nop, dst: bus.i1_dst,
                   ra: bus.i1_ra, rb: bus.i1_rb, rc: bus.i1_rc, use_ra: bus.i1_use_ra,
                   use_rb: bus.i1_use_rb, use_rc: bus.i1_use_rc, lat: bus.i1_lat};
    assign in2 = '{typ: bus.i2_type, wr: bus.i2_wr, nop: bus.i2_nop, dst: bus.i2_dst,
                   ra: bus.i2_ra, rb: bus.i2_rb, rc: bus.i2_rc, use_ra: bus.i2_use_ra,
                   use_rb: bus.i2_use_rb, use_rc: bus.i2_use_rc, lat: bus.i2_lat};

    // A nop slot is never blocked; otherwise every read source and the destination must be idle.
    function automatic logic instr_ready(instr_t x);
        logic ok;
        ok = 1'b1;
        if (!x.nop) begin
            if (x.use_ra && cnt[x.ra] != '0) ok = 1'b0;
            if (x.use_rb && cnt[x.rb] != '0) ok = 1'b0;
            if (x.use_rc && cnt[x.rc] != '0) ok = 1'b0;
            if (x.wr && cnt[x.dst] != '0) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [LAT_W-1:0] load_value(logic [LAT_W-1:0] lat);
        return (lat == '0) ? '0 : lat - 1'b1;
    endfunction

    always_comb begin
        rdy1    = instr_ready(h1);
        rdy2    = instr_ready(h2);
        w1      = h1.wr & ~h1.nop;
        w2      = h2.wr & ~h2.nop;
        rd_dep  = ~h2.nop & ((h2.use_ra & (h2.ra == h1.dst)) |
                             (h2.use_rb & (h2.rb == h1.dst)) |
                             (h2.use_rc & (h2.rc == h1.dst)));
        pair_ok = (h1.typ != h2.typ) && !(w1 && rd_dep) && !(w1 && w2 && h1.dst == h2.dst) && rdy2;
    end

    always_comb begin
        state_n = state;
        iss1    = 1'b0;
        iss2    = 1'b0;
        stall_i = 1'b0;
        ready_i = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: ready_i = 1'b1;
            PAIR: begin
                if (rdy1) begin
                    iss1 = 1'b1;
                    if (pair_ok) begin
                        iss2    = 1'b1;
                        ready_i = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SECOND;
                    end
                end else begin
                    stall_i = 1'b1;
                end
            end
            SECOND: begin
                if (rdy2) begin
                    iss2    = 1'b1;
                    ready_i = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall_i = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus.flush) begin
            iss1    = 1'b0;
            iss2    = 1'b0;
            stall_i = 1'b0;
            ready_i = 1'b0;
            state_n = IDLE;
        end else if (bus.pair_valid && ready_i) begin
            accept  = 1'b1;
            state_n = PAIR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            h1        <= '0;
            h2        <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                h1 <= in1;
                h2 <= in2;
            end
            if (stall_i && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Even and odd writers in one cycle never share a destination, so the load order is irrelevant.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset)                                       cnt[r] <= '0;
            else if (iss1 && w1 && h1.dst == REG_W'(r))      cnt[r] <= load_value(h1.lat);
            else if (iss2 && w2 && h2.dst == REG_W'(r))      cnt[r] <= load_value(h2.lat);
            else if (cnt[r] != '0)                           cnt[r] <= cnt[r] - 1'b1;
        end
    end

    assign bus.pair_ready  = ready_i;
    assign bus.stall       = stall_i;
    assign bus.stall_count = stall_cnt;
    assign bus.even_issue  = (iss1 & ~h1.typ) | (iss2 & ~h2.typ);
    assign bus.even_slot   = iss2 & ~h2.typ;
    assign bus.odd_issue   = (iss1 & h1.typ) | (iss2 & h2.typ);
    assign bus.odd_slot    = iss2 & h2.typ;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - scoreboard bench for dual_issue_scheduler against a ready-time model
module tb_dual_issue_scheduler;
    typedef struct packed {
        logic       typ;
        logic       wr;
        logic       nop;
        logic [6:0] dst;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic       use_ra;
        logic       use_rb;
        logic       use_rc;
        logic [3:0] lat;
    } instr_t;

    typedef struct {
        int          cyc;
        bit          pr, ei, es, oi, os, st;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.REG_W(7), .LAT_W(4), .CNT_W(32)) bus ();
    dual_issue_scheduler #(.NUM_REGS(128), .REG_W(7), .LAT_W(4), .CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];
    instr_t      held[$];
    int          ready_at [128];
    int          t = 0;
    logic [31:0] sc = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("pair_ready",  e.cyc, 32'(bus.pair_ready), 32'(e.pr));
            check("even_issue",  e.cyc, 32'(bus.even_issue), 32'(e.ei));
            check("even_slot",   e.cyc, 32'(bus.even_slot),  32'(e.es));
            check("odd_issue",   e.cyc, 32'(bus.odd_issue),  32'(e.oi));
            check("odd_slot",    e.cyc, 32'(bus.odd_slot),   32'(e.os));
            check("stall",       e.cyc, 32'(bus.stall),      32'(e.st));
            check("stall_count", e.cyc, bus.stall_count,     e.sc);
        end
    end

    // Reference model: a register is usable from the cycle its producer's latency has elapsed.
    function automatic bit reads(instr_t x, logic [6:0] r);
        return !x.nop && ((x.use_ra && x.ra == r) || (x.use_rb && x.rb == r) || (x.use_rc && x.rc == r));
    endfunction

    function automatic bit writes(instr_t x);
        return x.wr && !x.nop;
    endfunction

    function automatic bit m_ready(instr_t x);
        if (x.nop) return 1'b1;
        if (x.use_ra && ready_at[x.ra] > t) return 1'b0;
        if (x.use_rb && ready_at[x.rb] > t) return 1'b0;
        if (x.use_rc && ready_at[x.rc] > t) return 1'b0;
        if (x.wr && ready_at[x.dst] > t) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_pair(instr_t x, instr_t y);
        if (x.typ == y.typ) return 1'b0;
        if (writes(x) && reads(y, x.dst)) return 1'b0;
        if (writes(x) && writes(y) && x.dst == y.dst) return 1'b0;
        return m_ready(y);
    endfunction

    task automatic drive(input bit v, input bit fl, input instr_t a, input instr_t b);
        bus.pair_valid = v;  bus.flush = fl;
        bus.i1_type = a.typ; bus.i1_wr = a.wr; bus.i1_nop = a.nop; bus.i1_dst = a.dst;
        bus.i1_ra = a.ra; bus.i1_rb = a.rb; bus.i1_rc = a.rc; bus.i1_lat = a.lat;
        bus.i1_use_ra = a.use_ra; bus.i1_use_rb = a.use_rb; bus.i1_use_rc = a.use_rc;
        bus.i2_type = b.typ; bus.i2_wr = b.wr; bus.i2_nop = b.nop; bus.i2_dst = b.dst;
        bus.i2_ra = b.ra; bus.i2_rb = b.rb; bus.i2_rc = b.rc; bus.i2_lat = b.lat;
        bus.i2_use_ra = b.use_ra; bus.i2_use_rb = b.use_rb; bus.i2_use_rc = b.use_rc;
    endtask

    task automatic step(input bit v, input bit fl, input instr_t a, input instr_t b, output bit acc);
        exp_t e;
        int   n_iss;
        bit   slot;
        @(posedge clk); #1;
        drive(v, fl, a, b);
        e = '{cyc: t, pr: 0, ei: 0, es: 0, oi: 0, os: 0, st: 0, sc: sc};
        n_iss = 0;
        if (!fl && held.size() > 0) begin
            if (m_ready(held[0])) n_iss = (held.size() == 2 && m_pair(held[0], held[1])) ? 2 : 1;
            e.st = (n_iss == 0);
            for (int k = 0; k < n_iss; k++) begin
                slot = (k == 1) || (held.size() == 1);
                if (held[k].typ) begin e.oi = 1; e.os = slot; end
                else             begin e.ei = 1; e.es = slot; end
            end
            for (int k = 0; k < n_iss; k++)
                if (writes(held[k])) ready_at[held[k].dst] = t + ((held[k].lat == 0) ? 1 : int'(held[k].lat));
            repeat (n_iss) void'(held.pop_front());
        end
        e.pr = !fl && held.size() == 0;
        acc  = v && e.pr;
        if (fl) held.delete();
        if (acc) begin held.push_back(a); held.push_back(b); end
        if (e.st && sc != 32'hFFFF_FFFF) sc++;
        q.push_back(e);
        t++;
    endtask

    function automatic instr_t mk(int typ, int wr, int dst, int ra, int ura, int rb, int urb, int lat);
        instr_t x;
        x = '0;
        x.typ = 1'(typ); x.wr = 1'(wr); x.dst = 7'(dst);
        x.ra = 7'(ra); x.use_ra = 1'(ura); x.rb = 7'(rb); x.use_rb = 1'(urb); x.lat = 4'(lat);
        return x;
    endfunction

    function automatic instr_t mk_nop(int typ);
        instr_t x;
        x = '0;
        x.typ = 1'(typ); x.nop = 1'b1; x.wr = 1'b1; x.dst = 7'd10;
        return x;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t x;
        x.typ = 1'($urandom_range(0, 1));
        x.wr = ($urandom_range(0, 3) != 0);
        x.nop = ($urandom_range(0, 7) == 0);
        x.dst = 7'($urandom_range(0, 7));
        x.ra = 7'($urandom_range(0, 7));
        x.rb = 7'($urandom_range(0, 7));
        x.rc = 7'($urandom_range(0, 7));
        x.use_ra = 1'($urandom_range(0, 1));
        x.use_rb = 1'($urandom_range(0, 1));
        x.use_rc = 1'($urandom_range(0, 1));
        x.lat = 4'($urandom_range(0, 7));
        return x;
    endfunction

    task automatic send(input instr_t a, input instr_t b);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            step(1, 0, a, b, acc);
            n++;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(0, 0, rnd_instr(), rnd_instr(), acc);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.pair_valid = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        held.delete();
        foreach (ready_at[i]) ready_at[i] = 0;
        sc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        drive(0, 0, '0, '0);
        do_reset();
        idle(2);
        send(mk(0, 1, 3, 1, 1, 2, 1, 1), mk(1, 1, 4, 5, 1, 0, 0, 4));
        idle(4);
        send(mk(0, 1, 20, 21, 1, 22, 1, 1), mk(0, 1, 23, 24, 1, 0, 0, 1));
        idle(4);
        send(mk(0, 1, 10, 0, 0, 0, 0, 6), mk_nop(1));
        send(mk(0, 1, 11, 10, 1, 0, 0, 1), mk_nop(1));
        idle(8);
        send(mk(0, 1, 7, 0, 0, 0, 0, 2), mk(1, 1, 8, 7, 1, 0, 0, 1));
        idle(5);
        send(mk(0, 1, 30, 0, 0, 0, 0, 7), mk_nop(1));
        send(mk(0, 1, 31, 0, 0, 0, 0, 1), mk(1, 1, 32, 30, 1, 0, 0, 1));
        idle(1);
        step(1, 1, mk(0, 0, 0, 0, 0, 0, 0, 1), mk_nop(1), acc);
        send(mk(1, 1, 33, 30, 1, 0, 0, 1), mk_nop(0));
        idle(8);
        send(mk(0, 1, 40, 0, 0, 0, 0, 0), mk_nop(1));
        send(mk(0, 1, 42, 40, 1, 0, 0, 1), mk_nop(1));
        send(mk(0, 1, 41, 0, 0, 0, 0, 5), mk_nop(1));
        send(mk(1, 1, 41, 0, 0, 0, 0, 1), mk_nop(0));
        idle(8);
        send(mk(0, 1, 50, 0, 0, 0, 0, 7), mk_nop(1));
        send(mk(0, 1, 51, 50, 1, 0, 0, 3), mk(1, 1, 52, 50, 1, 0, 0, 1));
        idle(2);
        do_reset();
        send(mk(0, 1, 53, 50, 1, 0, 0, 1), mk(1, 1, 54, 51, 1, 0, 0, 1));
        idle(3);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, rnd_instr(), rnd_instr(), acc);
        idle(12);
        @(negedge clk); #1;
        check("queue_drained", t, 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
